// File: rtl/sprite_plot_arbiter.sv
// Round-robin arbiter that merges the sprite clients' pixel streams onto the single VGA write port.
// A grant lasts for one whole burst. Pixels that fall off-screen are dropped at the output stage.
module sprite_plot_arbiter #(
    parameter int unsigned N_CLIENTS = 3,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned C_W       = 3,
    parameter int unsigned X_MAX     = 159,
    parameter int unsigned Y_MAX     = 119,
    parameter int unsigned HOLD_MAX  = 255
) (
    input  logic                     clk,
    input  logic                     reset_N,
    input  logic [N_CLIENTS-1:0]     req,
    input  logic [N_CLIENTS-1:0]     pix_valid,
    input  logic [N_CLIENTS-1:0]     pix_last,
    input  logic [N_CLIENTS*X_W-1:0] pix_x,
    input  logic [N_CLIENTS*Y_W-1:0] pix_y,
    input  logic [N_CLIENTS*C_W-1:0] pix_colour,
    output logic [N_CLIENTS-1:0]     gnt,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [C_W-1:0]           vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e          state_q;
    logic            run_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [7:0]      hold_cnt_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            cur_req;
    logic            cur_valid;
    logic            cur_last;
    logic [X_W-1:0]  cur_x;
    logic [Y_W-1:0]  cur_y;
    logic [C_W-1:0]  cur_colour;
    logic            on_screen;
    logic            burst_done;
    logic [IW-1:0]   next_ptr;

    // Scan downward so the requester closest to rr_ptr (lowest offset) is the one kept.
    always_comb begin
        int c;
        c          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = int'(N_CLIENTS) - 1; i >= 0; i--) begin
            c = int'(rr_ptr_q) + i;
            if (c >= int'(N_CLIENTS)) c = c - int'(N_CLIENTS);
            if (req[c]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(c);
            end
        end
    end

    always_comb begin
        cur_req    = req[idx_q];
        cur_valid  = pix_valid[idx_q];
        cur_last   = pix_last[idx_q];
        cur_x      = pix_x[idx_q*X_W +: X_W];
        cur_y      = pix_y[idx_q*Y_W +: Y_W];
        cur_colour = pix_colour[idx_q*C_W +: C_W];
        on_screen  = (cur_x <= X_W'(X_MAX)) && (cur_y <= Y_W'(Y_MAX));
        burst_done = cur_valid && cur_last;
        next_ptr   = (idx_q == IW'(N_CLIENTS - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= StIdle;
            run_q       <= 1'b0;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            gnt         <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // First edge after reset release only arms the FSM.
            run_q    <= 1'b1;
            vga_plot <= 1'b0;

            if (state_q == StGrant && cur_valid) begin
                vga_x      <= cur_x;
                vga_y      <= cur_y;
                vga_colour <= cur_colour;
                vga_plot   <= on_screen;
            end

            case (state_q)
                StIdle: begin
                    if (run_q && pick_found) begin
                        gnt        <= N_CLIENTS'(1) << pick_idx;
                        idx_q      <= pick_idx;
                        busy       <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    if (hold_cnt_q != 8'hFF) hold_cnt_q <= hold_cnt_q + 8'd1;
                    if (burst_done || !cur_req || hold_cnt_q == 8'(HOLD_MAX)) begin
                        if (!burst_done && cur_req) timeout_err <= 1'b1;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StRelease;
                    end
                end
                StRelease: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

endmodule
